// File: rtl/my_pkg.sv
// Shared types and default timing constants for the I2C master driver.
package my_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [6:0] address_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ADDR     = 3'd2,
    ADDR_ACK = 3'd3,
    WDATA    = 3'd4,
    DATA_ACK = 3'd5,
    STOP     = 3'd6
  } i2c_mst_state_t;

  localparam int I2C_SCL_HALF    = 4;
  localparam int I2C_ACK_TIMEOUT = 16;

endpackage

// File: rtl/i2c_bit_timer.sv
// SCL half-period timer: phase_end marks the last clk of each half period,
// and the counter reloads itself there so phases run back to back.
module i2c_bit_timer
  import my_pkg::*;
#(
  parameter int SCL_HALF = I2C_SCL_HALF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic phase_end
);

  localparam logic [7:0] RELOAD = 8'(SCL_HALF - 1);

  logic [7:0] cnt_q, cnt_d;

  assign phase_end = en && (cnt_q == 8'd0);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load || phase_end) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_master_driver.sv
// Single-byte I2C-style master: START, 7-bit address + R/W, ACK slot,
// optional write-data byte with ACK slot, then STOP.
module i2c_master_driver
  import my_pkg::*;
#(
  parameter int SCL_HALF    = I2C_SCL_HALF,
  parameter int ACK_TIMEOUT = I2C_ACK_TIMEOUT
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     start_req,
  input  logic     rw,
  input  address_t addr,
  input  byte_t    wdata,
  input  logic     ACKT,
  output logic     SDA,
  output logic     SCL,
  output logic     busy,
  output logic     done,
  output logic     nack
);

  localparam int               ACK_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  i2c_mst_state_t   state_q, state_d;
  logic             sda_q, sda_d;
  logic             scl_q, scl_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic             ack_seen_q, ack_seen_d;
  address_t         addr_q, addr_d;
  logic             rw_q, rw_d;
  byte_t            wdata_q, wdata_d;

  logic  timer_load;
  logic  timer_en;
  logic  phase_end;
  logic  ack_now;
  byte_t cur_byte;

  i2c_bit_timer #(.SCL_HALF(SCL_HALF)) u_bit_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .en       (timer_en),
    .phase_end(phase_end)
  );

  assign timer_en = (state_q != IDLE);
  assign cur_byte = (state_q == ADDR) ? {addr_q, rw_q} : wdata_q;
  assign ack_now  = ack_seen_q | ACKT;

  always_comb begin
    state_d    = state_q;
    sda_d      = sda_q;
    scl_d      = scl_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    nack_d     = nack_q;
    bit_cnt_d  = bit_cnt_q;
    ack_cnt_d  = ack_cnt_q;
    ack_seen_d = ack_seen_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    timer_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        sda_d  = 1'b1;
        scl_d  = 1'b1;
        busy_d = 1'b0;
        if (start_req) begin
          addr_d     = addr;
          rw_d       = rw;
          wdata_d    = wdata;
          busy_d     = 1'b1;
          nack_d     = 1'b0;
          sda_d      = 1'b0;
          timer_load = 1'b1;
          state_d    = START;
        end
      end

      START: begin
        if (phase_end) begin
          scl_d     = 1'b0;
          sda_d     = addr_q[6];
          bit_cnt_d = 3'd7;
          state_d   = ADDR;
        end
      end

      ADDR, WDATA: begin
        if (phase_end) begin
          if (!scl_q) begin
            scl_d = 1'b1;
          end else begin
            scl_d = 1'b0;
            if (bit_cnt_q != 3'd0) begin
              bit_cnt_d = bit_cnt_q - 3'd1;
              sda_d     = cur_byte[bit_cnt_q - 3'd1];
            end else begin
              sda_d      = 1'b1;
              ack_cnt_d  = '0;
              ack_seen_d = 1'b0;
              state_d    = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
            end
          end
        end
      end

      ADDR_ACK, DATA_ACK: begin
        ack_seen_d = ack_now;
        if (!ack_now) begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
        // The timeout restarts the timer so STOP gets full-length phases.
        if (!ack_now && (ack_cnt_q == ACK_LAST)) begin
          nack_d     = 1'b1;
          scl_d      = 1'b0;
          sda_d      = 1'b0;
          timer_load = 1'b1;
          state_d    = STOP;
        end else if (phase_end) begin
          if (!scl_q) begin
            // SCL stays low until an acknowledge has been seen.
            if (ack_now) begin
              scl_d = 1'b1;
            end
          end else begin
            scl_d = 1'b0;
            if ((state_q == ADDR_ACK) && !rw_q) begin
              sda_d     = wdata_q[7];
              bit_cnt_d = 3'd7;
              state_d   = WDATA;
            end else begin
              sda_d   = 1'b0;
              state_d = STOP;
            end
          end
        end
      end

      STOP: begin
        if (phase_end) begin
          if (!scl_q) begin
            scl_d = 1'b1;
          end else begin
            sda_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the latched request fields are reset as well, so nothing downstream ever sees X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sda_q      <= 1'b1;
      scl_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      bit_cnt_q  <= 3'd0;
      ack_cnt_q  <= '0;
      ack_seen_q <= 1'b0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      sda_q      <= sda_d;
      scl_q      <= scl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      bit_cnt_q  <= bit_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      ack_seen_q <= ack_seen_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
    end
  end

  assign SDA  = sda_q;
  assign SCL  = scl_q;
  assign busy = busy_q;
  assign done = done_q;
  assign nack = nack_q;

endmodule

// File: doc/i2c_master_driver.md
I2C_MASTER_DRIVER -- requirements
Module: i2c_master_driver

Interface
REQ-001 SHALL have parameter SCL_HALF, default 4: clk cycles per SCL half-period, legal range 1..255.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16: clk cycles to wait for ACKT in an ACK slot.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on posedge clk.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start_req, input, 1 bit: user requests one transaction.
REQ-006 SHALL have port rw, input, 1 bit: 0 = write, 1 = read.
REQ-007 SHALL have port addr, input, address_t: 7-bit target memory address.
REQ-008 SHALL have port wdata, input, byte_t: write data byte.
REQ-009 SHALL have port ACKT, input, 1 bit: acknowledge from the downstream controller.
REQ-010 SHALL have port SDA, output, 1 bit: serial data line.
REQ-011 SHALL have port SCL, output, 1 bit: serial clock line.
REQ-012 SHALL have port busy, output, 1 bit: transaction in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at transaction end.
REQ-014 SHALL have port nack, output, 1 bit: last transaction timed out waiting for ACKT.

Function
REQ-015 FSM states SHALL be IDLE, START, ADDR, ADDR_ACK, WDATA, DATA_ACK, STOP.
REQ-016 In IDLE: SDA=1, SCL=1, busy=0.
REQ-017 In IDLE, start_req=1 SHALL be accepted: latch addr, rw, wdata; set busy=1 on the next cycle; clear nack; go to START.
REQ-018 start_req while busy=1 SHALL be ignored; latched fields SHALL stay stable until done.
REQ-019 START: SDA=0 with SCL=1 for SCL_HALF cycles, then SCL=0; go to ADDR.
REQ-020 Bit slot: SDA updates only on entry to the SCL-low phase; SCL low for SCL_HALF cycles, then high for SCL_HALF cycles.
REQ-021 ADDR SHALL send 8 slots, MSB first: addr[6:0], then rw.
REQ-022 ACK slot (ADDR_ACK, DATA_ACK): SDA=1 (released); SCL pulses as a bit slot; ACKT sampled every clk from slot entry.
REQ-023 If ACKT is seen within ACK_TIMEOUT cycles, the slot completes its SCL pulse and advances: ADDR_ACK goes to WDATA when rw=0 and to STOP when rw=1; DATA_ACK goes to STOP.
REQ-024 If ACKT is not seen within ACK_TIMEOUT cycles: set nack=1 (held until next accept); go to STOP.
REQ-025 WDATA SHALL send wdata[7:0] MSB first in 8 slots.
REQ-026 STOP: SCL=0, SDA=0 for SCL_HALF cycles; then SCL=1, SDA=0 for SCL_HALF cycles; then SDA=1; go to IDLE.
REQ-027 done=1 for exactly one cycle on the STOP-to-IDLE transition; busy=0 in that same cycle.
REQ-028 Bit counter: 3 bits, counting 7 down to 0; no wrap beyond 8 slots per byte.
REQ-029 Half-period counter SHALL reload to SCL_HALF-1 at each phase boundary; SCL_HALF=1 gives a 2-clk bit.
REQ-030 A new start_req SHALL be accepted in the cycle after done (back-to-back frames).

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE, SDA=1, SCL=1, busy=0, done=0, nack=0, all counters 0; this applies mid-frame too, with no STOP generated.

Structure
REQ-032 byte_t, address_t and the state enum i2c_mst_state_t SHALL reside in my_pkg, with default constants I2C_SCL_HALF and I2C_ACK_TIMEOUT.
REQ-033 The half-period counter SHALL be sub-module i2c_bit_timer (inputs: load, en; output: phase_end).

Verification
REQ-034 Write: addr=7'h2A, rw=0, wdata=8'hC3, ACKT asserted in each ACK slot -> SDA bits 0101010 0, then 11000011, then STOP; done pulses once; nack=0.
REQ-035 Read: addr=7'h15, rw=1, ACKT asserted -> bits 0010101 1, no data phase, STOP, done pulse, nack=0.
REQ-036 NACK: ACKT held 0 -> after 16 cycles in ADDR_ACK, nack=1, STOP issued, done pulse.
REQ-037 start_req pulsed mid-frame with addr=7'h7F -> ignored; the frame in progress is unchanged.
REQ-038 reset_n low during WDATA bit 3 -> SDA=1, SCL=1, busy=0 in the same cycle; the next request completes normally.
REQ-039 Back-to-back: a second start_req in the cycle after done -> accepted; SCL_HALF=1 case checked for a 2-clk bit period.
